// File: rtl/register_writeback_unit_pkg.sv
// Shared core types for the register file write path.
//   RegAddress : 5-bit architectural register index
//   RegData    : 32-bit register value
//   X0_ADDRESS : hard-wired zero register; writes to it are discarded
package JZJCoreFTypes;
  localparam int XLEN = 32;

  typedef logic [4:0]      RegAddress;
  typedef logic [XLEN-1:0] RegData;

  localparam RegAddress X0_ADDRESS = 5'd0;

  // True when a write to this register actually changes architectural state.
  function automatic logic isWritable(input RegAddress a);
    return a != X0_ADDRESS;
  endfunction
endpackage

// File: rtl/register_writeback_unit_fifo.sv
// pending_address_fifo: in-order queue of outstanding load destinations.
//   clock, reset       : core clock, async active-low reset
//   push, pushAddress  : enqueue (ignored while full)
//   pop, headAddress   : dequeue / oldest entry (pop ignored while empty)
//   full, empty, count : occupancy
//   entries, validMask : raw storage plus live-entry mask for hazard compare
module pending_address_fifo
  import JZJCoreFTypes::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  RegAddress              pushAddress,
  input  logic                   pop,
  output RegAddress              headAddress,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  output RegAddress [DEPTH-1:0]  entries,
  output logic [DEPTH-1:0]       validMask
);
  RegAddress [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  doPush, doPop;
  logic [PW-1:0]         offset;

  assign full        = count_q == CW'(DEPTH);
  assign empty       = count_q == '0;
  assign doPush      = push && !full;
  assign doPop       = pop && !empty;
  assign headAddress = mem_q[rdPtr_q];
  assign count       = count_q;
  assign entries     = mem_q;

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the
  // occupancy; the power-of-two depth makes the subtraction wrap for free.
  always_comb begin
    offset    = '0;
    validMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - rdPtr_q;
      validMask[i] = CW'(offset) < count_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushAddress;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (doPop) rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/register_writeback_unit.sv
// register_writeback_unit: merges ALU results and in-order load returns onto
// the register file's single write port and flags RAW hazards to decode.
//   aluValid/aluRdAddress/aluResult       : single-cycle result, wins the port
//   loadIssue/loadIssueRdAddress/-Ready   : record a load destination
//   loadDataValid/loadData/loadDataReady  : load return into the hold stage
//   rs1Address/rs2Address/hazardStall     : decode source hazard check
//   rdAddress/rd/rdWriteEnable            : registered write port
//   pendingCount                          : outstanding loads in the queue
//   protocolError                         : sticky misuse flag
module register_writeback_unit
  import JZJCoreFTypes::*;
#(
  parameter  int LOAD_DEPTH = 4,
  localparam int CW         = $clog2(LOAD_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          aluValid,
  input  RegAddress     aluRdAddress,
  input  RegData        aluResult,
  input  logic          loadIssue,
  input  RegAddress     loadIssueRdAddress,
  output logic          loadIssueReady,
  input  logic          loadDataValid,
  input  RegData        loadData,
  output logic          loadDataReady,
  input  RegAddress     rs1Address,
  input  RegAddress     rs2Address,
  output logic          hazardStall,
  output RegAddress     rdAddress,
  output RegData        rd,
  output logic          rdWriteEnable,
  output logic [CW-1:0] pendingCount,
  output logic          protocolError
);
  RegAddress                  headAddress;
  RegAddress [LOAD_DEPTH-1:0] entries;
  logic [LOAD_DEPTH-1:0]      validMask;
  logic                       qFull, qEmpty, loadAccept;

  logic      holdValid_q, holdValid_d;
  RegAddress holdAddress_q, holdAddress_d;
  RegData    holdData_q, holdData_d;
  RegAddress rdAddress_q, rdAddress_d;
  RegData    rd_q, rd_d;
  logic      rdWe_q, rdWe_d;
  logic      protocolError_q, protocolError_d;

  // Readiness looks only at registered occupancy: no credit for a pop that
  // happens on the same edge.
  assign loadIssueReady = !qFull;
  // Hold can take new data unless it is occupied and blocked by the ALU.
  assign loadDataReady  = !qEmpty && (!holdValid_q || !aluValid);
  assign loadAccept     = loadDataValid && loadDataReady;

  pending_address_fifo #(.DEPTH(LOAD_DEPTH)) u_pending (
    .clock      (clock),
    .reset      (reset),
    .push       (loadIssue && loadIssueReady),
    .pushAddress(loadIssueRdAddress),
    .pop        (loadAccept),
    .headAddress(headAddress),
    .full       (qFull),
    .empty      (qEmpty),
    .count      (pendingCount),
    .entries    (entries),
    .validMask  (validMask)
  );

  always_comb begin
    holdValid_d     = holdValid_q;
    holdAddress_d   = holdAddress_q;
    holdData_d      = holdData_q;
    rdAddress_d     = rdAddress_q;
    rd_d            = rd_q;
    rdWe_d          = 1'b0;
    protocolError_d = protocolError_q
                    | (loadIssue && qFull)
                    | (loadDataValid && qEmpty);

    if (aluValid) begin
      rdAddress_d = aluRdAddress;
      rd_d        = aluResult;
      rdWe_d      = isWritable(aluRdAddress);
    end else if (holdValid_q) begin
      rdAddress_d = holdAddress_q;
      rd_d        = holdData_q;
      rdWe_d      = isWritable(holdAddress_q);
      holdValid_d = 1'b0;
    end

    // A refill on the same edge as a drain overrides the clear above.
    if (loadAccept) begin
      holdValid_d   = 1'b1;
      holdAddress_d = headAddress;
      holdData_d    = loadData;
    end
  end

  always_comb begin
    hazardStall = 1'b0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      if (validMask[i] && ((isWritable(rs1Address) && entries[i] == rs1Address) ||
                           (isWritable(rs2Address) && entries[i] == rs2Address)))
        hazardStall = 1'b1;
    end
    if (holdValid_q && ((isWritable(rs1Address) && holdAddress_q == rs1Address) ||
                        (isWritable(rs2Address) && holdAddress_q == rs2Address)))
      hazardStall = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      holdValid_q     <= 1'b0;
      holdAddress_q   <= X0_ADDRESS;
      holdData_q      <= '0;
      rdAddress_q     <= X0_ADDRESS;
      rd_q            <= '0;
      rdWe_q          <= 1'b0;
      protocolError_q <= 1'b0;
    end else begin
      holdValid_q     <= holdValid_d;
      holdAddress_q   <= holdAddress_d;
      holdData_q      <= holdData_d;
      rdAddress_q     <= rdAddress_d;
      rd_q            <= rd_d;
      rdWe_q          <= rdWe_d;
      protocolError_q <= protocolError_d;
    end
  end

  assign rdAddress     = rdAddress_q;
  assign rd            = rd_q;
  assign rdWriteEnable = rdWe_q;
  assign protocolError = protocolError_q;
endmodule

// File: tb/tb_register_writeback_unit.sv
module tb_register_writeback_unit;
  localparam int LOAD_DEPTH = 4;
  localparam int CW = $clog2(LOAD_DEPTH + 1);

  logic          clock, reset;
  logic          aluValid;
  logic [4:0]    aluRdAddress;
  logic [31:0]   aluResult;
  logic          loadIssue;
  logic [4:0]    loadIssueRdAddress;
  logic          loadIssueReady;
  logic          loadDataValid;
  logic [31:0]   loadData;
  logic          loadDataReady;
  logic [4:0]    rs1Address, rs2Address;
  logic          hazardStall;
  logic [4:0]    rdAddress;
  logic [31:0]   rd;
  logic          rdWriteEnable;
  logic [CW-1:0] pendingCount;
  logic          protocolError;

  int checks = 0;
  int errors = 0;

  register_writeback_unit #(.LOAD_DEPTH(LOAD_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .aluValid(aluValid), .aluRdAddress(aluRdAddress), .aluResult(aluResult),
    .loadIssue(loadIssue), .loadIssueRdAddress(loadIssueRdAddress),
    .loadIssueReady(loadIssueReady),
    .loadDataValid(loadDataValid), .loadData(loadData), .loadDataReady(loadDataReady),
    .rs1Address(rs1Address), .rs2Address(rs2Address), .hazardStall(hazardStall),
    .rdAddress(rdAddress), .rd(rd), .rdWriteEnable(rdWriteEnable),
    .pendingCount(pendingCount), .protocolError(protocolError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    aluValid = 0; aluRdAddress = 0; aluResult = 0;
    loadIssue = 0; loadIssueRdAddress = 0;
    loadDataValid = 0; loadData = 0;
    rs1Address = 0; rs2Address = 0;
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    step(); step();
    checks++; if (rdWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rdWriteEnable); end
    checks++; if (rdAddress !== 5'd0) begin errors++; $display("FAIL reset_rdaddr got %0d exp 0", rdAddress); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd); end
    checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pendingCount); end
    checks++; if (loadIssueReady !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %0b exp 1", loadIssueReady); end
    checks++; if (loadDataReady !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %0b exp 0", loadDataReady); end
    checks++; if (protocolError !== 1'b0) begin errors++; $display("FAIL reset_perr got %0b exp 0", protocolError); end
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b exp 0", hazardStall); end
    reset = 1;
    step();
  endtask

  task automatic test_alu();
    aluValid = 1; aluRdAddress = 5; aluResult = 32'hDEADBEEF;
    step();
    idle();
    checks++; if (rdWriteEnable !== 1'b1) begin errors++; $display("FAIL alu_we got %0b exp 1", rdWriteEnable); end
    checks++; if (rdAddress !== 5'd5) begin errors++; $display("FAIL alu_addr got %0d exp 5", rdAddress); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got %h exp deadbeef", rd); end
    step();
    checks++; if (rdWriteEnable !== 1'b0) begin errors++; $display("FAIL alu_we_drop got %0b exp 0", rdWriteEnable); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      aluValid = 1; aluRdAddress = 5'(20 + i); aluResult = vals[i];
      step();
      checks++;
      if (rdWriteEnable !== 1'b1 || rdAddress !== 5'(20 + i) || rd !== vals[i]) begin
        errors++;
        $display("FAIL b2b_%0d got we=%0b a=%0d d=%h exp we=1 a=%0d d=%h",
                 i, rdWriteEnable, rdAddress, rd, 20 + i, vals[i]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_load_hazard();
    loadIssue = 1; loadIssueRdAddress = 7;
    step();
    idle(); rs1Address = 7; #1;
    checks++; if (hazardStall !== 1'b1) begin errors++; $display("FAIL ld_hazard_q got %0b exp 1", hazardStall); end
    checks++; if (pendingCount !== 3'd1) begin errors++; $display("FAIL ld_count got %0d exp 1", pendingCount); end
    checks++; if (loadDataReady !== 1'b1) begin errors++; $display("FAIL ld_ready got %0b exp 1", loadDataReady); end
    loadDataValid = 1; loadData = 32'h12345678;
    step();
    loadDataValid = 0; #1;
    checks++; if (hazardStall !== 1'b1) begin errors++; $display("FAIL ld_hazard_hold got %0b exp 1", hazardStall); end
    checks++; if (rdWriteEnable !== 1'b0) begin errors++; $display("FAIL ld_we_early got %0b exp 0", rdWriteEnable); end
    checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL ld_count_pop got %0d exp 0", pendingCount); end
    step();
    checks++;
    if (rdWriteEnable !== 1'b1 || rdAddress !== 5'd7 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL ld_write got we=%0b a=%0d d=%h exp we=1 a=7 d=12345678", rdWriteEnable, rdAddress, rd);
    end
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL ld_hazard_clear got %0b exp 0", hazardStall); end
    idle();
    step();
  endtask

  task automatic test_contention();
    loadIssue = 1; loadIssueRdAddress = 10; step();
    loadIssueRdAddress = 11; step();
    idle();
    loadDataValid = 1; loadData = 32'hAAAA0000; step();   // hold <= x10
    aluValid = 1; aluRdAddress = 3; aluResult = 32'hCCCC0003;
    loadDataValid = 1; loadData = 32'hBBBB0000; #1;
    checks++; if (loadDataReady !== 1'b0) begin errors++; $display("FAIL cont_ready got %0b exp 0", loadDataReady); end
    step();
    aluValid = 0; #1;
    checks++;
    if (rdWriteEnable !== 1'b1 || rdAddress !== 5'd3 || rd !== 32'hCCCC0003) begin
      errors++;
      $display("FAIL cont_alu got we=%0b a=%0d d=%h exp we=1 a=3 d=cccc0003", rdWriteEnable, rdAddress, rd);
    end
    checks++; if (pendingCount !== 3'd1) begin errors++; $display("FAIL cont_count got %0d exp 1", pendingCount); end
    checks++; if (loadDataReady !== 1'b1) begin errors++; $display("FAIL cont_ready2 got %0b exp 1", loadDataReady); end
    step();   // hold drains x10, refilled with x11
    loadDataValid = 0;
    checks++;
    if (rdWriteEnable !== 1'b1 || rdAddress !== 5'd10 || rd !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL cont_hold got we=%0b a=%0d d=%h exp we=1 a=10 d=aaaa0000", rdWriteEnable, rdAddress, rd);
    end
    step();
    checks++;
    if (rdWriteEnable !== 1'b1 || rdAddress !== 5'd11 || rd !== 32'hBBBB0000) begin
      errors++;
      $display("FAIL cont_next got we=%0b a=%0d d=%h exp we=1 a=11 d=bbbb0000", rdWriteEnable, rdAddress, rd);
    end
    idle();
    step();
  endtask

  task automatic test_x0();
    aluValid = 1; aluRdAddress = 0; aluResult = 32'hFFFFFFFF;
    step();
    idle();
    checks++; if (rdWriteEnable !== 1'b0) begin errors++; $display("FAIL x0_alu_we got %0b exp 0", rdWriteEnable); end
    loadIssue = 1; loadIssueRdAddress = 0;
    step();
    idle(); #1;
    checks++; if (pendingCount !== 3'd1) begin errors++; $display("FAIL x0_count got %0d exp 1", pendingCount); end
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL x0_hazard got %0b exp 0", hazardStall); end
    loadDataValid = 1; loadData = 32'h0BADF00D;
    step();
    loadDataValid = 0;
    checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL x0_pop got %0d exp 0", pendingCount); end
    step();
    checks++; if (rdWriteEnable !== 1'b0) begin errors++; $display("FAIL x0_ld_we got %0b exp 0", rdWriteEnable); end
    step();
  endtask

  task automatic test_full();
    logic [4:0]  addrs [4];
    logic [31:0] data  [4];
    addrs[0] = 1; addrs[1] = 2; addrs[2] = 4; addrs[3] = 8;
    data[0] = 32'hD0000001; data[1] = 32'hD0000002; data[2] = 32'hD0000004; data[3] = 32'hD0000008;
    for (int i = 0; i < 4; i++) begin
      loadIssue = 1; loadIssueRdAddress = addrs[i];
      step();
    end
    idle();
    checks++; if (loadIssueReady !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", loadIssueReady); end
    checks++; if (pendingCount !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", pendingCount); end
    checks++; if (protocolError !== 1'b0) begin errors++; $display("FAIL full_perr_pre got %0b exp 0", protocolError); end
    loadIssue = 1; loadIssueRdAddress = 9;
    step();
    idle(); rs1Address = 9; rs2Address = 4; #1;
    checks++; if (protocolError !== 1'b1) begin errors++; $display("FAIL full_perr got %0b exp 1", protocolError); end
    checks++; if (pendingCount !== 3'd4) begin errors++; $display("FAIL full_count_drop got %0d exp 4", pendingCount); end
    checks++; if (hazardStall !== 1'b1) begin errors++; $display("FAIL full_hazard_rs2 got %0b exp 1", hazardStall); end
    rs2Address = 0; #1;
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL full_hazard_dropped got %0b exp 0", hazardStall); end
    rs1Address = 0;
    for (int i = 0; i < 5; i++) begin
      loadDataValid = (i < 4); loadData = (i < 4) ? data[i] : 32'd0;
      step();
      if (i > 0) begin
        checks++;
        if (rdWriteEnable !== 1'b1 || rdAddress !== addrs[i-1] || rd !== data[i-1]) begin
          errors++;
          $display("FAIL full_order_%0d got we=%0b a=%0d d=%h exp we=1 a=%0d d=%h",
                   i - 1, rdWriteEnable, rdAddress, rd, addrs[i-1], data[i-1]);
        end
      end
    end
    idle();
    checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", pendingCount); end
    step();
  endtask

  task automatic test_reset_mid();
    loadIssue = 1; loadIssueRdAddress = 5; step();
    loadIssueRdAddress = 6; step();
    loadIssueRdAddress = 7; step();
    idle();
    loadDataValid = 1; loadData = 32'h50505050; step();
    loadData = 32'h60606060; step();
    checks++; if (rdWriteEnable !== 1'b1) begin errors++; $display("FAIL rmid_we_pre got %0b exp 1", rdWriteEnable); end
    rs1Address = 6;
    reset = 0; #1;
    checks++; if (rdWriteEnable !== 1'b0 || rdAddress !== 5'd0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL rmid_port got we=%0b a=%0d d=%h exp 0/0/0", rdWriteEnable, rdAddress, rd);
    end
    checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", pendingCount); end
    checks++; if (protocolError !== 1'b0) begin errors++; $display("FAIL rmid_perr got %0b exp 0", protocolError); end
    checks++; if (hazardStall !== 1'b0) begin errors++; $display("FAIL rmid_hazard got %0b exp 0", hazardStall); end
    checks++; if (loadIssueReady !== 1'b1 || loadDataReady !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ready got issue=%0b data=%0b exp 1/0", loadIssueReady, loadDataReady);
    end
    #2 reset = 1;
    step();
    loadDataValid = 0;
    checks++; if (protocolError !== 1'b1) begin errors++; $display("FAIL rmid_perr_after got %0b exp 1", protocolError); end
    checks++; if (rdWriteEnable !== 1'b0) begin errors++; $display("FAIL rmid_we_after got %0b exp 0", rdWriteEnable); end
    idle();
    step();
  endtask

  initial begin
    reset = 0;
    idle();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_hazard();
    test_contention();
    test_x0();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_writeback_unit.md
# register_writeback_unit

Write-side front end for the core's 32×32 register file: merges single-cycle ALU results and multi-cycle load returns into the register file's single write port (rd, rd address, write enable). Tracks destination registers of outstanding loads in an in-order pending queue and flags read-after-write hazards to decode. Sits between the execute/memory units and the register file write port.

## Interface
- LOAD_DEPTH, 4, maximum outstanding loads (power of two, ≥2)
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- aluValid  in  1  ALU result present this cycle
- aluRdAddress  in  5  ALU destination
- aluResult  in  32  ALU result
- loadIssue  in  1  load issued this cycle
- loadIssueRdAddress  in  5  issued load's destination
- loadIssueReady  out  1  pending queue not full
- loadDataValid  in  1  load data returning (in issue order)
- loadData  in  32  returned load data
- loadDataReady  out  1  unit accepts load data this cycle
- rs1Address, rs2Address  in  5 each  decode source addresses
- hazardStall  out  1  a source matches a pending load destination
- rdAddress  out  5  to register file write address
- rd  out  32  to register file write data
- rdWriteEnable  out  1  to register file write enable
- pendingCount  out  $clog2(LOAD_DEPTH+1)  entries in pending queue
- protocolError  out  1  sticky misuse flag

## Operation
- Pending queue: FIFO of 5-bit addresses, LOAD_DEPTH entries. Push on loadIssue && loadIssueReady; loadIssue while full is dropped and sets protocolError.
- Hold stage: one register (holdValid, holdAddress, holdData). Load accept = loadDataValid && loadDataReady: pops queue head into holdAddress, loadData into holdData, sets holdValid.
- loadDataValid while queue empty: ignored, not accepted, sets protocolError.
- loadDataReady = queue non-empty && (!holdValid || !aluValid).
- Arbitration each cycle: aluValid wins the write port; otherwise holdValid drains (holdValid clears unless refilled same edge).
- Output register: selected source's address/data captured into rdAddress/rd; rdWriteEnable = source valid && address ≠ 0. x0 destinations still pop/drain but never assert rdWriteEnable.
- hazardStall (combinational) = for rs1Address or rs2Address ≠ 0, match against any valid queue entry or holdAddress when holdValid.
- Write-after-write: ALU write to a register with a pending load proceeds; the later load write overwrites it. No reordering.
- loadIssueReady = count < LOAD_DEPTH from registered state only (no same-cycle pop credit).
- Simultaneous push and pop: both occur; count unchanged.
- protocolError clears only on reset.

## Timing
- Reset (async assert, sync-deassert supplied externally): rdWriteEnable=0, rdAddress=0, rd=0, queue empty, holdValid=0, pendingCount=0, protocolError=0, loadIssueReady=1, loadDataReady=0, hazardStall=0. Reset mid-operation discards all pending loads.
- ALU: aluValid in cycle N → rdWriteEnable high in N+1.
- Load: accepted in N → written in N+1 edge earliest → rdWriteEnable high in N+2; each cycle of ALU contention adds one cycle.
- Throughput: one register write per cycle.
- hazardStall clears the cycle after the matching load drains from hold (same cycle its rdWriteEnable is visible).

## Structure
- Shared package JZJCoreFTypes: add RegAddress (5-bit) typedef and X0_ADDRESS constant; reuse for aluRdAddress/loadIssueRdAddress.
- Sub-module pending_address_fifo (parameterised depth, push/pop/full/empty/count, exposes all entries plus valid mask for hazard compare).
- Top holds arbitration, hold stage, output register, error flag.

## Test plan
- Reset then aluValid, aluRdAddress=5, aluResult=32'hDEADBEEF → next cycle rdWriteEnable=1, rdAddress=5, rd=32'hDEADBEEF.
- Issue load to x7; rs1Address=7 → hazardStall=1; loadData=32'h12345678 returned → rdWriteEnable with x7/32'h12345678 two cycles later, hazardStall=0 same cycle.
- Hold full + aluValid to x3 + loadDataValid → loadDataReady=0, ALU written first, held load next cycle, new load accepted after.
- Issue 4 loads (LOAD_DEPTH=4) → loadIssueReady=0, pendingCount=4; fifth issue dropped, protocolError=1; return order matches issue order.
- ALU write and load both targeting x0 → rdWriteEnable stays 0; load still pops (pendingCount decrements).
- Assert reset with 3 pending loads mid-return → all outputs to reset values immediately; subsequent loadDataValid sets protocolError.
